// File: rtl/tim_pkg.sv
// tim_pkg: shared mode type, default width and helpers for the tim_pwm_nch timer
//   TIM_CNT_W       default width of counter, PSC, ARR and CCR
//   tim_mode_e      counting mode (up / down / center)
//   tim_mode_decode maps the raw 2-bit mode field, the reserved code runs as up
//   ccr_lsb         lowest bit of channel ch inside the packed CCR word
package tim_pkg;

    localparam int TIM_CNT_W = 16;

    typedef enum logic [1:0] {
        TIM_UP     = 2'b00,
        TIM_DOWN   = 2'b01,
        TIM_CENTER = 2'b10
    } tim_mode_e;

    function automatic tim_mode_e tim_mode_decode(input logic [1:0] m);
        return (m == 2'b01) ? TIM_DOWN : (m == 2'b10) ? TIM_CENTER : TIM_UP;
    endfunction

    function automatic int ccr_lsb(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/tim_pwm_nch_if.sv
// tim_pwm_nch_if: configuration bus from the datapath into the timer
//   timer_en  run enable
//   mode_i    counting mode, opm_i one-pulse mode
//   psc_i     prescaler, arr_i auto-reload, ccr_i packed compare values
//   cfg_wr    loads psc/arr/ccr/mode into the preload registers
//   ch_en     per-channel output enable, ch_pol per-channel polarity
//   master drives the bus (datapath), slave receives it (timer)
interface tim_pwm_nch_if #(
    parameter int CNT_W = tim_pkg::TIM_CNT_W,
    parameter int NCH   = 4
);

    logic                 timer_en;
    logic [1:0]           mode_i;
    logic                 opm_i;
    logic [CNT_W-1:0]     psc_i;
    logic [CNT_W-1:0]     arr_i;
    logic [NCH*CNT_W-1:0] ccr_i;
    logic                 cfg_wr;
    logic [NCH-1:0]       ch_en;
    logic [NCH-1:0]       ch_pol;

    modport master (
        output timer_en, mode_i, opm_i, psc_i, arr_i, ccr_i, cfg_wr, ch_en, ch_pol
    );

    modport slave (
        input timer_en, mode_i, opm_i, psc_i, arr_i, ccr_i, cfg_wr, ch_en, ch_pol
    );

endinterface

// File: rtl/tim_pwm_ch.sv
// tim_pwm_ch: one compare/PWM channel with its CCR preload and active registers
//   clk, reset  clock, asynchronous active-low reset
//   cfg_wr_i    load ccr_i into the preload register
//   load_i      copy preload into the active CCR
//   tick_i      prescaler tick, cnt_d_i is the counter value after this tick
//   cnt_i       current counter value
//   en_i/pol_i  output enable and polarity
//   cc_flag_o   registered compare-match pulse
//   pwm_o       registered polarity-adjusted PWM output
module tim_pwm_ch
    import tim_pkg::*;
#(
    parameter int CNT_W = TIM_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_wr_i,
    input  logic [CNT_W-1:0] ccr_i,
    input  logic             load_i,
    input  logic             tick_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [CNT_W-1:0] cnt_d_i,
    input  logic             en_i,
    input  logic             pol_i,
    output logic             cc_flag_o,
    output logic             pwm_o
);

    logic [CNT_W-1:0] ccr_pre_q, ccr_q;
    logic             flag_q, flag_d, pwm_q, pwm_d;

    always_comb begin
        flag_d = tick_i && (cnt_d_i == ccr_q);
        pwm_d  = en_i ? ((cnt_i < ccr_q) ^ pol_i) : pol_i;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ccr_pre_q <= '0;
            ccr_q     <= '0;
            flag_q    <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            if (cfg_wr_i) ccr_pre_q <= ccr_i;
            if (load_i) ccr_q <= ccr_pre_q;
            flag_q <= flag_d;
            pwm_q  <= pwm_d;
        end
    end

    assign cc_flag_o = flag_q;
    assign pwm_o     = pwm_q;

endmodule

// File: rtl/tim_pwm_nch.sv
// tim_pwm_nch: prescaled up/down/center counter driving NCH compare/PWM channels
//   clk, reset  clock, asynchronous active-low reset
//   cfg         configuration bus (slave side of tim_pwm_nch_if)
//   cnt_o       active counter value, dir_o 1 while counting down
//   upd_o       registered update-event pulse
//   cc_flag_o   registered compare-match pulses, pwm_o registered PWM outputs
module tim_pwm_nch
    import tim_pkg::*;
#(
    parameter int CNT_W = TIM_CNT_W,
    parameter int NCH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    tim_pwm_nch_if.slave     cfg,
    output logic [CNT_W-1:0] cnt_o,
    output logic             dir_o,
    output logic             upd_o,
    output logic [NCH-1:0]   cc_flag_o,
    output logic [NCH-1:0]   pwm_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] psc_pre_q, arr_pre_q, psc_q, arr_q;
    logic [CNT_W-1:0] pcnt_q, pcnt_d, cnt_q, cnt_d;
    tim_mode_e        mode_pre_q, mode_q;
    logic             dir_q, dir_d, opm_done_q, opm_done_d, armed_q, armed_d;
    logic             upd_q, upd_ev, run, tick, load;

    always_comb begin
        run    = cfg.timer_en & ~opm_done_q;
        tick   = run & (pcnt_q == psc_q);
        pcnt_d = !run ? pcnt_q : tick ? '0 : pcnt_q + ONE;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        upd_ev = 1'b0;
        if (tick) begin
            case (mode_q)
                TIM_DOWN: begin
                    dir_d  = 1'b1;
                    upd_ev = cnt_q == '0;
                    cnt_d  = upd_ev ? arr_q : cnt_q - ONE;
                end
                TIM_CENTER: begin
                    if (arr_q == '0) begin
                        dir_d  = 1'b0;
                        upd_ev = 1'b1;
                        cnt_d  = '0;
                    end else if (!dir_q) begin
                        dir_d = cnt_q == arr_q;
                        cnt_d = dir_d ? arr_q - ONE : cnt_q + ONE;
                    end else begin
                        upd_ev = cnt_q == '0;
                        dir_d  = !upd_ev;
                        cnt_d  = upd_ev ? ONE : cnt_q - ONE;
                    end
                end
                default: begin
                    dir_d  = 1'b0;
                    upd_ev = cnt_q == arr_q;
                    cnt_d  = upd_ev ? '0 : cnt_q + ONE;
                end
            endcase
        end
        load    = !run | upd_ev;
        // The first tick after run rises may itself be an update (down mode reloading
        // from 0); one-pulse completion only counts updates after that first tick.
        armed_d = run & (armed_q | tick);
        opm_done_d = cfg.timer_en & (opm_done_q | (upd_ev & cfg.opm_i & armed_q));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_pre_q  <= '0;
            arr_pre_q  <= '0;
            mode_pre_q <= TIM_UP;
            psc_q      <= '0;
            arr_q      <= '0;
            mode_q     <= TIM_UP;
            pcnt_q     <= '0;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            opm_done_q <= 1'b0;
            armed_q    <= 1'b0;
            upd_q      <= 1'b0;
        end else begin
            if (cfg.cfg_wr) begin
                psc_pre_q  <= cfg.psc_i;
                arr_pre_q  <= cfg.arr_i;
                mode_pre_q <= tim_mode_decode(cfg.mode_i);
            end
            if (load) begin
                psc_q  <= psc_pre_q;
                arr_q  <= arr_pre_q;
                mode_q <= mode_pre_q;
            end
            pcnt_q     <= pcnt_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            opm_done_q <= opm_done_d;
            armed_q    <= armed_d;
            upd_q      <= upd_ev;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tim_pwm_ch #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .cfg_wr_i  (cfg.cfg_wr),
            .ccr_i     (cfg.ccr_i[ccr_lsb(i, CNT_W) +: CNT_W]),
            .load_i    (load),
            .tick_i    (tick),
            .cnt_i     (cnt_q),
            .cnt_d_i   (cnt_d),
            .en_i      (cfg.ch_en[i]),
            .pol_i     (cfg.ch_pol[i]),
            .cc_flag_o (cc_flag_o[i]),
            .pwm_o     (pwm_o[i])
        );
    end

    assign cnt_o = cnt_q;
    assign dir_o = dir_q;
    assign upd_o = upd_q;

endmodule

// File: tb/tb_tim_pwm_nch.sv
// tb_tim_pwm_nch: directed and randomized checks of tim_pwm_nch against a behavioural model
module tb_tim_pwm_nch;

    localparam int W    = 16;
    localparam int N    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] cnt_o;
    logic         dir_o, upd_o;
    logic [N-1:0] cc_flag_o, pwm_o;

    int checks = 0;
    int errors = 0;
    bit mon    = 1'b0;

    // model state: preload (p_), active (a_), counting state and expected registered outputs
    int p_psc, p_arr, p_mode, a_psc, a_arr, a_mode;
    int p_ccr[N];
    int a_ccr[N];
    int m_pc, m_cnt, m_dir, m_done, m_armed, m_upd;
    bit [N-1:0] m_flag, m_pwm;

    tim_pwm_nch_if #(.CNT_W(W), .NCH(N)) bus ();

    tim_pwm_nch #(.CNT_W(W), .NCH(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg       (bus),
        .cnt_o     (cnt_o),
        .dir_o     (dir_o),
        .upd_o     (upd_o),
        .cc_flag_o (cc_flag_o),
        .pwm_o     (pwm_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void m_zero();
        p_psc = 0; p_arr = 0; p_mode = 0; a_psc = 0; a_arr = 0; a_mode = 0;
        for (int i = 0; i < N; i++) begin p_ccr[i] = 0; a_ccr[i] = 0; end
        m_pc = 0; m_cnt = 0; m_dir = 0; m_done = 0; m_armed = 0; m_upd = 0;
        m_flag = '0; m_pwm = '0;
    endfunction

    // one clock edge of the specified behaviour, using the inputs held across that edge
    function automatic void m_step();
        bit run, tick, up;
        int nc, nd;
        if (!reset) begin
            m_zero();
            return;
        end
        run  = bus.timer_en && !m_done;
        tick = run && (m_pc == a_psc);
        up   = 0;
        nc   = m_cnt;
        nd   = m_dir;
        if (tick) begin
            if (a_mode == 1) begin
                nd = 1;
                if (m_cnt == 0) begin nc = a_arr; up = 1; end else nc = m_cnt - 1;
            end else if (a_mode == 2) begin
                if (a_arr == 0) begin nc = 0; nd = 0; up = 1; end
                else if (m_dir == 0) begin
                    if (m_cnt == a_arr) begin nd = 1; nc = a_arr - 1; end else nc = (m_cnt + 1) & MASK;
                end else begin
                    if (m_cnt == 0) begin nd = 0; nc = 1; up = 1; end else nc = m_cnt - 1;
                end
            end else begin
                nd = 0;
                if (m_cnt == a_arr) begin nc = 0; up = 1; end else nc = (m_cnt + 1) & MASK;
            end
        end
        for (int i = 0; i < N; i++) begin
            m_flag[i] = tick && (nc == a_ccr[i]);
            m_pwm[i]  = bus.ch_en[i] ? ((m_cnt < a_ccr[i]) ^ bus.ch_pol[i]) : bus.ch_pol[i];
        end
        m_upd = up;
        if (!bus.timer_en) m_done = 0;
        else if (up && bus.opm_i && m_armed) m_done = 1;
        m_armed = (run && (m_armed || tick)) ? 1 : 0;
        if (run) m_pc = tick ? 0 : m_pc + 1;
        m_cnt = nc;
        m_dir = nd;
        if (!run || up) begin
            a_psc = p_psc; a_arr = p_arr; a_mode = p_mode;
            for (int i = 0; i < N; i++) a_ccr[i] = p_ccr[i];
        end
        if (bus.cfg_wr) begin
            p_psc  = int'(bus.psc_i);
            p_arr  = int'(bus.arr_i);
            p_mode = (bus.mode_i == 2'b11) ? 0 : int'(bus.mode_i);
            for (int i = 0; i < N; i++) p_ccr[i] = int'(bus.ccr_i[i*W +: W]);
        end
    endfunction

    always @(negedge clk) begin
        if (mon) begin
            chk("cnt_o", cnt_o, m_cnt);
            chk("dir_o", dir_o, m_dir);
            chk("upd_o", upd_o, m_upd);
            chk("cc_flag_o", cc_flag_o, m_flag);
            chk("pwm_o", pwm_o, m_pwm);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            m_step();
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        m_zero();
        cyc(2);
        reset = 1'b1;
    endtask

    task automatic cfg(input int mode, input int psc, input int arr, input logic [N*W-1:0] ccr,
                       input logic [N-1:0] en, input logic [N-1:0] pol, input bit opm);
        bus.mode_i = 2'(mode);
        bus.psc_i  = W'(psc);
        bus.arr_i  = W'(arr);
        bus.ccr_i  = ccr;
        bus.ch_en  = en;
        bus.ch_pol = pol;
        bus.opm_i  = opm;
        bus.cfg_wr = 1'b1;
        cyc();
        bus.cfg_wr = 1'b0;
        cyc();
    endtask

    task automatic next_upd(output int g);
        g = 0;
        do begin
            cyc();
            g++;
        end while (!upd_o && g < 100);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required self-termination");
        $fatal(1);
    end

    initial begin
        int nu, first, second, hp0, nf0, h1, h2, h3, g, n;
        int ec[10]  = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
        int ed[10]  = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        int eu[10]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        int eo[10]  = '{5, 4, 3, 2, 1, 0, 5, 5, 5, 5};
        int eou[10] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        bus.timer_en = 1'b0; bus.mode_i = '0; bus.opm_i = 1'b0; bus.psc_i = '0; bus.arr_i = '0;
        bus.ccr_i = '0; bus.cfg_wr = 1'b0; bus.ch_en = '0; bus.ch_pol = '0;
        #1;
        reset = 1'b0;
        m_zero();
        mon = 1'b1;
        cyc();
        chk("reset_cnt", cnt_o, 0);
        chk("reset_pwm", pwm_o, 0);
        chk("reset_upd", upd_o, 0);
        reset = 1'b1;

        // up mode PWM with boundary channels: ch1 disabled pol=1, ch2 CCR=0, ch3 CCR>ARR inverted
        do_reset();
        cfg(0, 1, 9, {16'd10, 16'd0, 16'd7, 16'd3}, 4'b1101, 4'b1010, 1'b0);
        bus.timer_en = 1'b1;
        nu = 0; first = -1; second = -1; hp0 = 0; nf0 = 0; h1 = 0; h2 = 0; h3 = 0;
        for (int k = 0; k < 60; k++) begin
            cyc();
            if (upd_o) begin
                nu++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            hp0 += int'(pwm_o[0]);
            nf0 += int'(cc_flag_o[0]);
            h1  += int'(pwm_o[1]);
            h2  += int'(pwm_o[2]);
            h3  += int'(pwm_o[3]);
        end
        chk("up_upd_count", nu, 3);
        chk("up_upd_period", second - first, 20);
        chk("up_pwm0_high", hp0, 18);
        chk("up_cc0_count", nf0, 3);
        chk("pwm1_disabled_pol", h1, 60);
        chk("pwm2_ccr_zero", h2, 0);
        chk("pwm3_ccr_over_arr_inv", h3, 0);

        // ARR rewrite 8 clocks into a period: current period stays 20, next is 10
        cyc(7);
        bus.arr_i  = W'(4);
        bus.cfg_wr = 1'b1;
        cyc();
        bus.cfg_wr = 1'b0;
        next_upd(g);
        chk("preload_cur_period", g + 8, 20);
        next_upd(g);
        chk("preload_next_period", g, 10);

        // center mode
        do_reset();
        bus.timer_en = 1'b0;
        cfg(2, 0, 4, {16'd0, 16'd0, 16'd2, 16'd0}, 4'hF, 4'h0, 1'b0);
        bus.timer_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("center_cnt", cnt_o, ec[k]);
            chk("center_dir", dir_o, ed[k]);
            chk("center_upd", upd_o, eu[k]);
        end

        // down mode, one-pulse
        do_reset();
        bus.timer_en = 1'b0;
        cfg(1, 0, 5, '0, 4'hF, 4'h0, 1'b1);
        bus.timer_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("opm_cnt", cnt_o, eo[k]);
            chk("opm_upd", upd_o, eou[k]);
        end
        cyc(20);
        chk("opm_frozen", cnt_o, 5);
        bus.timer_en = 1'b0;
        cyc();
        bus.timer_en = 1'b1;
        cyc();
        chk("opm_rearm", cnt_o, 4);
        bus.opm_i = 1'b0;

        // asynchronous reset mid-count
        do_reset();
        bus.timer_en = 1'b0;
        cfg(0, 0, 20, {48'd0, 16'd10}, 4'h1, 4'h0, 1'b0);
        bus.timer_en = 1'b1;
        n = 0;
        while (cnt_o != W'(7) && n < 50) begin
            cyc();
            n++;
        end
        chk("rst_reach7", cnt_o, 7);
        chk("rst_pre_pwm", pwm_o, 1);
        #2;
        reset = 1'b0;
        m_zero();
        #1;
        chk("rst_async_cnt", cnt_o, 0);
        chk("rst_async_pwm", pwm_o, 0);
        cyc();
        reset = 1'b1;
        chk("rst_release_cnt", cnt_o, 0);
        cyc();
        chk("rst_restart_cnt", cnt_o, 0);
        chk("rst_restart_upd", upd_o, 1);

        // randomized configuration traffic against the model
        do_reset();
        bus.timer_en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            bus.cfg_wr = 1'b0;
            if ($urandom_range(15) == 0) begin
                bus.cfg_wr = 1'b1;
                if ($urandom_range(3) == 0) bus.mode_i = 2'($urandom_range(3));
                bus.psc_i = W'($urandom_range(3));
                bus.arr_i = W'($urandom_range(12));
                for (int i = 0; i < N; i++) bus.ccr_i[i*W +: W] = W'($urandom_range(14));
            end
            if ($urandom_range(63) == 0) bus.timer_en = ~bus.timer_en;
            if ($urandom_range(31) == 0) bus.opm_i = 1'($urandom_range(1));
            if ($urandom_range(31) == 0) begin
                bus.ch_en  = N'($urandom);
                bus.ch_pol = N'($urandom);
            end
            if ($urandom_range(499) == 0) begin
                reset = 1'b0;
                m_zero();
                cyc();
                reset = 1'b1;
            end
            cyc();
        end

        mon = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tim_pwm_nch.md
# tim_pwm_nch

Parametrised general-purpose timer, successor to the microcontroller's single two-channel PWM timer. One prescaler and one counter of configurable width drive NCH compare/PWM channels. Up, down and center-aligned counting are supported, with preloaded (shadowed) PSC/ARR/CCR values and a one-pulse mode. The block sits beside the datapath: the datapath supplies the configuration words and `timer_en`; the outputs go to pins and to the interrupt logic.

## Interface
- CNT_W, 16: width of counter, PSC, ARR and each CCR.
- NCH, 4: number of compare/PWM channels (1..8).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- timer_en  in  1  run enable.
- mode_i  in  2  counting mode: 00 up, 01 down, 10 center, 11 treated as up.
- opm_i  in  1  one-pulse mode.
- psc_i  in  CNT_W  prescaler value; tick period is psc+1 clocks.
- arr_i  in  CNT_W  auto-reload value.
- ccr_i  in  NCH*CNT_W  compare values; channel i occupies bits [i*CNT_W +: CNT_W].
- cfg_wr  in  1  writes psc_i, arr_i, ccr_i and mode_i into the preload registers.
- ch_en  in  NCH  channel output enable.
- ch_pol  in  NCH  channel polarity; 1 inverts the output and sets the idle level high.
- cnt_o  out  CNT_W  active counter value.
- dir_o  out  1  0 = counting up, 1 = counting down.
- upd_o  out  1  one-cycle update-event pulse.
- cc_flag_o  out  NCH  one-cycle compare-match pulses.
- pwm_o  out  NCH  PWM outputs.

## Operation
- **Reset values:** all outputs and internal state are 0. This covers cnt, the prescaler count, dir, the preload registers, the active registers, the opm_done flag and pwm_o.
- **Preload and active registers**
  - cfg_wr loads the preload registers on any cycle.
  - Active registers copy the preload registers every cycle while `run` = 0.
  - While `run` = 1 they copy only on the cycle of an update event.
- **Run control**
  - run = timer_en & ~opm_done.
  - When run is 0, the counter, the prescaler count and dir hold their values.
  - Deasserting timer_en clears opm_done.
- **Prescaler:** while running, the prescaler count increments. When it equals PSC, it wraps to 0 and asserts `tick` for that cycle.
- **Counter behaviour on tick**
  - Up: if cnt == ARR, cnt <= 0 and an update event occurs; otherwise cnt+1.
  - Down: if cnt == 0, cnt <= ARR and an update event occurs; otherwise cnt-1.
  - Center, dir = 0: if cnt == ARR, set dir <= 1 and cnt <= ARR-1; otherwise cnt+1.
  - Center, dir = 1: if cnt == 0, set dir <= 0, cnt <= 1 and an update event occurs; otherwise cnt-1.
  - Center with ARR = 0: cnt stays 0 and an update event occurs every tick.
  - Up and down modes force dir to the mode's direction.
- **Update event**
  - upd_o pulses one cycle later (registered).
  - In one-pulse mode, opm_done is set and the counter holds the value it wrapped to.
- **Compare:** cc_flag_o[i] pulses the cycle after any tick whose next cnt equals CCR[i].
- **PWM**
  - raw[i] = (cnt < CCR[i]).
  - pwm_o[i] = ch_en[i] ? raw[i] ^ ch_pol[i] : ch_pol[i]; this is registered.
  - CCR = 0 gives a constant inactive output; CCR > ARR gives a constant active output.
- **Mode change:** changes take effect only through the preload path, never mid-period.
- **Simultaneous cfg_wr and update event:** the active registers take the old preload value, and the new value applies at the following update event.

## Timing
- The counter changes on the clock edge that ends the tick cycle.
- cnt_o and dir_o are the register outputs, with zero added latency.
- upd_o, cc_flag_o and pwm_o lag the counter state by one clock.
- Up-mode period is (PSC+1)*(ARR+1) clocks. Down mode is the same. Center mode is (PSC+1)*2*ARR clocks.
- Reset asserted mid-period immediately forces all state and outputs to 0. Operation restarts from cnt = 0 after reset is released.

## Structure
- Shared package `tim_pkg` holds:
  - the `tim_mode_e` enum (TIM_UP, TIM_DOWN, TIM_CENTER);
  - the default CNT_W;
  - the CCR slice helper function.
- Sub-module `tim_pwm_ch` is instantiated NCH times. Each instance holds its CCR shadow register, the compare-match flag and the registered polarity-adjusted output.

## Test plan
- **Up-mode PWM:** NCH=4, CNT_W=16, PSC=1, ARR=9, CCR0=3, ch_en=1, pol=0, up mode.
  - upd_o every 20 clocks.
  - pwm_o[0] high for 6 clocks of each 20.
  - cc_flag_o[0] once per period.
- **Preload rewrite while running:** same setup, write ARR=4 mid-period.
  - The current period completes at ARR=9; the next period lasts 10 clocks.
- **Center mode:** center, PSC=0, ARR=4, CCR1=2.
  - cnt sequence 0,1,2,3,4,3,2,1,0,1…
  - upd_o only on the wrap 0→1; pwm_o[1] symmetric.
  - dir_o toggles at 4 and at 0.
- **Down mode, one-pulse:** down, opm=1, ARR=5.
  - First tick from 0 reloads 5, producing one update.
  - Counting continues 5→0, then a second update.
  - The counter freezes and stays frozen until timer_en drops and rises again.
- **Boundary CCR values and polarity:** CCR2=0, CCR3=ARR+1, pol[3]=1, ch_en[1]=0 with pol[1]=1.
  - pwm_o[2] stays 0.
  - pwm_o[3] stays 0 (active-high inverted).
  - pwm_o[1] stays 1.
- **Reset mid-count:** assert reset at cnt=7.
  - Outputs go to 0 within the same cycle, asynchronously.
  - After release with timer_en=1, cnt restarts from 0.
